uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter.sv | 152 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler that shares one uart_tx serializer
// between NREQ byte requesters. A winner's byte is accepted with a one-cycle
// req_ready pulse, launched with a one-cycle tx_send_en, and held on
// tx_data/tx_bps_set until uart_tx reports tx_done. The owner is then told with
// a one-cycle req_done pulse, and arbitration starts again.
//
// Optional build macro UART_TX_ARB_TIMEOUT_EN adds a WAIT watchdog. When it
// fires, timeout_err and req_done pulse together and the arbiter returns to
// IDLE. Without the macro, timeout_err is tied low and WAIT lasts until tx_done.
module uart_tx_arbiter #(
  parameter int NREQ        = 4,      // 2..8 requesters
  parameter int GUARD_CYC   = 4,      // tx_done ignored for this many WAIT cycles
  parameter int TIMEOUT_CYC = 65536   // WAIT watchdog limit in clk cycles
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [8*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]     req_ready,
  output logic [NREQ-1:0]     req_done,
  input  logic [2:0]          cfg_bps_set,
  output logic                tx_send_en,
  output logic [7:0]          tx_data,
  output logic [2:0]          tx_bps_set,
  input  logic                tx_done,
  output logic                busy,
  output logic [2:0]          grant_id,
  output logic                timeout_err
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam logic [2:0]      RR_INIT   = 3'(NREQ - 1);
  localparam logic [15:0]     GUARD_LIM = 16'(GUARD_CYC);
  localparam logic [NREQ-1:0] ONE_HOT0  = NREQ'(1);

  state_t      state;
  logic [2:0]  rr_ptr;
  logic [15:0] guard_cnt;

  // Requests padded to 8 lanes so a 3-bit index always fits exactly.
  logic [7:0]  valid_pad;
  logic [63:0] data_pad;
  logic        any_valid;
  logic [2:0]  winner;
  logic [7:0]  winner_data;
  logic        done_ok;

  assign valid_pad   = 8'(req_valid);
  assign data_pad    = 64'(req_data);
  assign winner_data = data_pad[{winner, 3'b000} +: 8];
  assign done_ok     = tx_done && (guard_cnt >= GUARD_LIM);

  // Round-robin search: first pending requester after rr_ptr, with wrap.
  always_comb begin
    logic [3:0] idx;
    // NOTE: every variable gets a value before the loop, so no path leaves
    // one unassigned and no latch is inferred.
    any_valid = 1'b0;
    winner    = rr_ptr;
    idx       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = 4'(rr_ptr) + 4'(k);
      if (idx >= 4'(NREQ)) idx = idx - 4'(NREQ);
      if (!any_valid && valid_pad[idx[2:0]]) begin
        any_valid = 1'b1;
        winner    = idx[2:0];
      end
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam logic [16:0] TMO_LAST = 17'(TIMEOUT_CYC - 1);
  logic [16:0] tmo_cnt;
`else
  // No watchdog in this build.
  assign timeout_err = 1'b0;
`endif

  // Arbiter FSM with registered handshake and uart_tx outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      rr_ptr      <= RR_INIT;
      guard_cnt   <= '0;
      req_ready   <= '0;
      req_done    <= '0;
      tx_send_en  <= 1'b0;
      tx_data     <= '0;
      tx_bps_set  <= '0;
      busy        <= 1'b0;
      grant_id    <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments for all state, so every register sees
      // the pre-edge values; the pulse outputs default low each cycle here.
      req_ready  <= '0;
      req_done   <= '0;
      tx_send_en <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (any_valid) begin
            tx_data    <= winner_data;
            tx_bps_set <= cfg_bps_set;
            grant_id   <= winner;
            rr_ptr     <= winner;
            req_ready  <= ONE_HOT0 << winner;
            tx_send_en <= 1'b1;
            guard_cnt  <= '0;
            busy       <= 1'b1;
            state      <= ST_WAIT;
`ifdef UART_TX_ARB_TIMEOUT_EN
            tmo_cnt    <= '0;
`endif
          end
        end
        ST_WAIT: begin
          // The guard covers uart_tx's send_en synchroniser, so a stale
          // tx_done from the previous frame cannot close this one.
          if (guard_cnt < GUARD_LIM) guard_cnt <= guard_cnt + 16'd1;
`ifdef UART_TX_ARB_TIMEOUT_EN
          tmo_cnt <= tmo_cnt + 17'd1;
`endif
          if (done_ok) begin
            req_done <= ONE_HOT0 << grant_id;
            busy     <= 1'b0;
            state    <= ST_IDLE;
          end
`ifdef UART_TX_ARB_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            req_done    <= ONE_HOT0 << grant_id;
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= ST_IDLE;
          end
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter. The stimulus pushes the expected grants
// and completions into queues. A negedge monitor pops and compares them
// whenever the DUT pulses tx_send_en or req_done. A responder stands in for
// uart_tx and pulses tx_done a set number of cycles after each send_en.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [8*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   req_done;
  logic [2:0]        cfg_bps_set = '0;
  logic              tx_send_en;
  logic [7:0]        tx_data;
  logic [2:0]        tx_bps_set;
  logic              tx_done = 1'b0;
  logic              busy;
  logic [2:0]        grant_id;
  logic              timeout_err;

  uart_tx_arbiter #(.NREQ(NREQ), .GUARD_CYC(4), .TIMEOUT_CYC(65536)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .req_done(req_done),
    .cfg_bps_set(cfg_bps_set),
    .tx_send_en(tx_send_en), .tx_data(tx_data), .tx_bps_set(tx_bps_set),
    .tx_done(tx_done), .busy(busy), .grant_id(grant_id),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [2:0] id;
    logic [7:0] data;
    logic [2:0] bps;
  } grant_t;

  grant_t     exp_g[$];
  logic [2:0] exp_d[$];
  grant_t     cur = '0;
  int         send_cyc = 0;
  int         done_cyc = 0;

  task automatic push_grant(input logic [2:0] id, input logic [7:0] d, input logic [2:0] b);
    grant_t g;
    g.id = id; g.data = d; g.bps = b;
    exp_g.push_back(g);
  endtask

  task automatic push_done(input logic [2:0] id);
    exp_d.push_back(id);
  endtask

  // Monitor: compares each grant and completion against the queues, and
  // checks that the frame's data and baud select stay put while busy.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (tx_send_en) begin
        if (exp_g.size() == 0) check("unexpected_grant", 32'(grant_id), 32'hFF);
        else begin
          cur = exp_g.pop_front();
          send_cyc = cyc;
          check("grant_id", 32'(grant_id), 32'(cur.id));
          check("grant_data", 32'(tx_data), 32'(cur.data));
          check("grant_bps", 32'(tx_bps_set), 32'(cur.bps));
          check("grant_ready", 32'(req_ready), 32'(4'(32'd1 << cur.id)));
        end
      end else if (busy) begin
        check("hold_frame", {20'(0), tx_data, tx_bps_set, req_ready != 0},
              {20'(0), cur.data, cur.bps, 1'b0});
      end
      if (req_done != 0) begin
        if (exp_d.size() == 0) check("unexpected_done", 32'(req_done), 32'h0);
        else begin
          logic [2:0] id;
          id = exp_d.pop_front();
          done_cyc = cyc;
          check("done_owner", 32'(req_done), 32'(4'(32'd1 << id)));
        end
      end
    end
  end

  // ---------------- requester model ----------------
  logic [7:0] rq_bytes[NREQ][8];
  int         rq_cnt[NREQ] = '{default: 0};
  int         rq_pos[NREQ] = '{default: 0};

  task automatic refresh(input int i);
    req_valid[i] = (rq_pos[i] < rq_cnt[i]);
    req_data[8*i +: 8] = req_valid[i] ? rq_bytes[i][rq_pos[i]] : 8'h00;
  endtask

  task automatic load(input int i, input logic [7:0] b);
    rq_bytes[i][rq_cnt[i]] = b;
    rq_cnt[i]++;
    refresh(i);
  endtask

  // Each requester moves on to its next byte once it sees its ready pulse.
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < NREQ; i++)
      if (req_ready[i]) begin
        rq_pos[i]++;
        refresh(i);
      end
  end

  // ---------------- uart_tx stand-in ----------------
  logic auto_done  = 1'b0;
  logic early      = 1'b0;
  int   done_delay = 10;

  initial forever begin
    @(negedge clk);
    if (tx_send_en && auto_done) begin
      for (int j = 1; j <= done_delay; j++) begin
        @(negedge clk);
        tx_done = (j == done_delay) || (early && j == 3);
      end
      @(negedge clk);
      tx_done = 1'b0;
    end
  end

  // ---------------- helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      rq_pos[i] = rq_cnt[i];
      refresh(i);
    end
    repeat (3) begin
      @(negedge clk);
      check("reset_outputs",
            32'({tx_send_en, tx_data, tx_bps_set, busy, grant_id, req_ready, req_done, timeout_err}),
            32'h0);
    end
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((busy || req_valid != 0 || exp_g.size() != 0 || exp_d.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_completes"}, 32'(n < budget), 32'd1);
  endtask

  task automatic wait_grant(input string name, input int budget);
    int n;
    n = 0;
    while (!tx_send_en && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_granted"}, 32'(n < budget), 32'd1);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    do_reset();
    auto_done = 1'b1;

    // 1: single requester 2, byte A5, baud 4, one-cycle grant latency.
    @(negedge clk);
    cfg_bps_set = 3'd4;
    load(2, 8'hA5);
    push_grant(3'd2, 8'hA5, 3'd4);
    push_done(3'd2);
    @(negedge clk);
    check("t1_latency", 32'({tx_send_en, req_ready}), 32'({1'b1, 4'b0100}));
    wait_idle("t1", 100);

    // 2: all four at once after reset: grants 0,1,2,3.
    do_reset();
    @(negedge clk);
    cfg_bps_set = 3'd1;
    for (int i = 0; i < NREQ; i++) begin
      load(i, 8'h10 + 8'(i));
      push_grant(3'(i), 8'h10 + 8'(i), 3'd1);
      push_done(3'(i));
    end
    wait_idle("t2", 200);

    // 3: requester 1 continuous, requester 3 joins in frame one: 1,3,1,3.
    @(negedge clk);
    load(1, 8'h21);
    load(1, 8'h22);
    push_grant(3'd1, 8'h21, 3'd1);
    push_grant(3'd3, 8'h31, 3'd1);
    push_grant(3'd1, 8'h22, 3'd1);
    push_grant(3'd3, 8'h32, 3'd1);
    push_done(3'd1); push_done(3'd3); push_done(3'd1); push_done(3'd3);
    wait_grant("t3", 20);
    load(3, 8'h31);
    load(3, 8'h32);
    wait_idle("t3", 200);

    // 4: baud select changes mid-frame; it only takes effect at the next grant.
    @(negedge clk);
    cfg_bps_set = 3'd0;
    load(0, 8'h40);
    load(0, 8'h41);
    push_grant(3'd0, 8'h40, 3'd0);
    push_grant(3'd0, 8'h41, 3'd2);
    push_done(3'd0); push_done(3'd0);
    wait_grant("t4", 20);
    repeat (3) @(negedge clk);
    cfg_bps_set = 3'd2;
    wait_idle("t4", 200);

    // Guard boundary: tx_done at guard count 3 is ignored, at 4 it is taken.
    done_delay = 4;
    early = 1'b1;
    @(negedge clk);
    cfg_bps_set = 3'd5;
    load(2, 8'h77);
    push_grant(3'd2, 8'h77, 3'd5);
    push_done(3'd2);
    wait_idle("guard", 100);
    check("guard_done_latency", 32'(done_cyc - send_cyc), 32'd5);
    early = 1'b0;
    done_delay = 10;

    // tx_done while IDLE does nothing.
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    check("idle_tx_done_ignored", 32'({busy, req_done, tx_send_en}), 32'h0);

    // 5: tx_done never arrives.
    auto_done = 1'b0;
    @(negedge clk);
    cfg_bps_set = 3'd6;
    load(1, 8'h50);
    push_grant(3'd1, 8'h50, 3'd6);
`ifdef UART_TX_ARB_TIMEOUT_EN
    push_done(3'd1);
`endif
    wait_grant("t5", 20);
`ifdef UART_TX_ARB_TIMEOUT_EN
    begin
      int n;
      n = 0;
      while (!timeout_err && n < 70000) begin
        @(negedge clk);
        n++;
      end
      check("t5_timeout_seen", 32'(n < 70000), 32'd1);
      check("t5_timeout_cycles", 32'(cyc - send_cyc), 32'd65536);
      check("t5_back_to_idle", 32'({busy, req_done}), 32'({1'b0, 4'b0010}));
    end
`else
    repeat (200) @(negedge clk);
    check("t5_still_waiting", 32'({busy, timeout_err, req_done}), 32'({1'b1, 1'b0, 4'b0000}));
`endif

    // 6: reset in the middle of WAIT; no req_done, pointer back to NREQ-1.
    do_reset();
    @(negedge clk);
    cfg_bps_set = 3'd3;
    load(1, 8'h61);
    push_grant(3'd1, 8'h61, 3'd3);
    wait_grant("t6", 20);
    repeat (5) @(negedge clk);
    do_reset();
    auto_done = 1'b1;
    @(negedge clk);
    load(0, 8'h60);
    load(2, 8'h62);
    push_grant(3'd0, 8'h60, 3'd3);
    push_grant(3'd2, 8'h62, 3'd3);
    push_done(3'd0);
    push_done(3'd2);
    wait_idle("t6", 200);

    check("scoreboard_drained", 32'(exp_g.size() + exp_d.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
